data_memory_unit: RTL and testbench

- Data memory stage that sits directly downstream of the ALU in the single-cycle RV32I datapath.
- Takes the ALU result as the byte address and supports LB/LH/LW/LBU/LHU and SB/SH/SW.
- Reads are combinational so load data reaches write-back in the same cycle; stores commit on the rising clock edge.
- Provides fault detection, a sticky fault flag and a store counter for debug.

---
 rtl/data_memory_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_data_memory_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// Data memory stage for a single-cycle RV32I datapath.
// The ALU result is used as the byte address. Loads are combinational, so
// load data reaches write-back in the same cycle. Stores commit on the rising
// clock edge. The block also reports bad accesses, keeps a sticky fault flag
// and counts committed stores.
module data_memory_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        access_fault,
    output logic        fault_sticky,
    output logic [15:0] store_count
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Sign-extend a byte to a full word.
    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    // Sign-extend a halfword to a full word.
    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

    // Storage array, one 32-bit word per entry.
    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [31:0]       mem_word_d;

    logic              fault_sticky_q;
    logic              fault_sticky_d;
    logic [15:0]       store_count_q;
    logic [15:0]       store_count_d;

    // Address fields.
    logic [ADDR_W-1:0] word_idx_s;
    logic [1:0]        lane_s;

    // Access-size decode.
    logic              size_b_s;
    logic              size_h_s;
    logic              size_w_s;
    logic              unsigned_s;
    logic              f3_legal_s;

    // Fault terms.
    logic              access_s;
    logic              range_fault_s;
    logic              align_fault_s;
    logic              access_fault_s;

    // Read path.
    logic [31:0]       rd_word_s;
    logic [7:0]        rd_byte_s;
    logic [15:0]       rd_half_s;
    logic [31:0]       read_data_s;

    // Write path.
    logic              wr_en_s;
    logic [3:0]        wr_mask_s;
    logic [31:0]       wr_data_s;

    assign word_idx_s = addr[ADDR_W+1:2];
    assign lane_s     = addr[1:0];
    assign access_s   = mem_read | mem_write;

    // Decode funct3 into access size and signedness. Unsigned variants exist
    // only for loads, so they are illegal when paired with a store.
    always_comb begin
        size_b_s   = 1'b0;
        size_h_s   = 1'b0;
        size_w_s   = 1'b0;
        unsigned_s = 1'b0;
        f3_legal_s = 1'b0;
        case (funct3)
            F3_B: begin
                size_b_s   = 1'b1;
                f3_legal_s = 1'b1;
            end
            F3_H: begin
                size_h_s   = 1'b1;
                f3_legal_s = 1'b1;
            end
            F3_W: begin
                size_w_s   = 1'b1;
                f3_legal_s = 1'b1;
            end
            F3_BU: begin
                size_b_s   = 1'b1;
                unsigned_s = 1'b1;
                f3_legal_s = ~mem_write;
            end
            F3_HU: begin
                size_h_s   = 1'b1;
                unsigned_s = 1'b1;
                f3_legal_s = ~mem_write;
            end
            default: begin
                f3_legal_s = 1'b0;
            end
        endcase
    end

    // Classify the current access. Reset masks the fault so that a held
    // reset never reports a fault.
    always_comb begin
        range_fault_s = |addr[31:ADDR_W+2];
        align_fault_s = (size_h_s & addr[0]) | (size_w_s & (|addr[1:0]));
        if (reset) begin
            access_fault_s = 1'b0;
        end else if (access_s) begin
            access_fault_s = range_fault_s | align_fault_s | ~f3_legal_s;
        end else begin
            access_fault_s = 1'b0;
        end
    end

    // Select the addressed byte and halfword from the indexed word.
    always_comb begin
        rd_word_s = mem_q[word_idx_s];
        case (lane_s)
            2'd0:    rd_byte_s = rd_word_s[7:0];
            2'd1:    rd_byte_s = rd_word_s[15:8];
            2'd2:    rd_byte_s = rd_word_s[23:16];
            2'd3:    rd_byte_s = rd_word_s[31:24];
            default: rd_byte_s = 8'h00;
        endcase
        if (addr[1]) begin
            rd_half_s = rd_word_s[31:16];
        end else begin
            rd_half_s = rd_word_s[15:0];
        end
    end

    // Format the load result. A disabled or faulting load returns zero.
    always_comb begin
        read_data_s = 32'h0000_0000;
        if (reset || !mem_read || access_fault_s) begin
            read_data_s = 32'h0000_0000;
        end else if (size_b_s) begin
            if (unsigned_s) begin
                read_data_s = {24'h00_0000, rd_byte_s};
            end else begin
                read_data_s = sext8(rd_byte_s);
            end
        end else if (size_h_s) begin
            if (unsigned_s) begin
                read_data_s = {16'h0000, rd_half_s};
            end else begin
                read_data_s = sext16(rd_half_s);
            end
        end else if (size_w_s) begin
            read_data_s = rd_word_s;
        end else begin
            read_data_s = 32'h0000_0000;
        end
    end

    // Build the byte-lane mask and the lane-replicated store data.
    always_comb begin
        wr_mask_s = 4'b0000;
        wr_data_s = write_data;
        if (size_b_s) begin
            wr_mask_s = 4'b0001 << lane_s;
            wr_data_s = {4{write_data[7:0]}};
        end else if (size_h_s) begin
            if (addr[1]) begin
                wr_mask_s = 4'b1100;
            end else begin
                wr_mask_s = 4'b0011;
            end
            wr_data_s = {2{write_data[15:0]}};
        end else if (size_w_s) begin
            wr_mask_s = 4'b1111;
            wr_data_s = write_data;
        end else begin
            wr_mask_s = 4'b0000;
            wr_data_s = write_data;
        end
    end

    // Merge the store into the current word and work out the next state of
    // the status registers.
    always_comb begin
        wr_en_s = ~reset & mem_write & ~access_fault_s;
        for (int i = 0; i < 4; i++) begin
            if (wr_mask_s[i]) begin
                mem_word_d[8*i +: 8] = wr_data_s[8*i +: 8];
            end else begin
                mem_word_d[8*i +: 8] = rd_word_s[8*i +: 8];
            end
        end
        if (wr_en_s) begin
            store_count_d = store_count_q + 16'd1;
        end else begin
            store_count_d = store_count_q;
        end
        fault_sticky_d = fault_sticky_q | access_fault_s;
    end

    // Storage array: reset clears every word, and a valid store updates the
    // addressed word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (wr_en_s) begin
            mem_q[word_idx_s] <= mem_word_d;
        end
    end

    // Status registers: the sticky fault flag and the store counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_sticky_q <= 1'b0;
            store_count_q  <= 16'h0000;
        end else begin
            fault_sticky_q <= fault_sticky_d;
            store_count_q  <= store_count_d;
        end
    end

    assign read_data    = read_data_s;
    assign access_fault = access_fault_s;
    assign fault_sticky = fault_sticky_q;
    assign store_count  = store_count_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Testbench for data_memory_unit.
// A byte-array model predicts every output and is compared against the DUT on
// each falling edge. Directed literal checks pin the model to hand-computed
// values.
`timescale 1ns/1ps
module tb_data_memory_unit;

    localparam int DEPTH_WORDS = 256;
    localparam int ADDR_W      = 8;
    localparam int NBYTES      = DEPTH_WORDS * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        access_fault;
    logic        fault_sticky;
    logic [15:0] store_count;

    int total = 0;
    int bad   = 0;
    logic cmp_en = 1'b0;

    // Model state.
    logic [7:0]  mm [NBYTES];
    logic        m_sticky;
    logic [15:0] m_count;

    data_memory_unit #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .write_data(write_data),
        .read_data(read_data), .access_fault(access_fault),
        .fault_sticky(fault_sticky), .store_count(store_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Fault rules, written directly from the access definition.
    function automatic logic m_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a);
        if (!(rd || wr)) return 1'b0;
        if (a >= 32'(NBYTES)) return 1'b1;
        case (f3)
            3'b000: return 1'b0;
            3'b001: return a % 2 != 0;
            3'b010: return a % 4 != 0;
            3'b100: return wr;
            3'b101: return wr || (a % 2 != 0);
            default: return 1'b1;
        endcase
    endfunction

    // Load result computed from the byte-array model.
    function automatic logic [31:0] m_read(input logic rd, input logic wr, input logic [2:0] f3,
                                           input logic [31:0] a);
        int b;
        int h;
        if (!rd || m_fault(rd, wr, f3, a)) return 32'h0;
        b = int'(mm[a[9:0]]);
        h = int'(mm[a[9:0] + 10'd1]) * 256 + int'(mm[a[9:0]]);
        case (f3)
            3'b000: return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'b100: return 32'(b);
            3'b001: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'b101: return 32'(h);
            3'b010: return {mm[a[9:0] + 10'd3], mm[a[9:0] + 10'd2], mm[a[9:0] + 10'd1], mm[a[9:0]]};
            default: return 32'h0;
        endcase
    endfunction

    // Model update: asynchronous clear, then stores commit at the rising edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBYTES; i++) mm[i] <= 8'h00;
            m_sticky <= 1'b0;
            m_count  <= 16'h0;
        end else if (m_fault(mem_read, mem_write, funct3, addr)) begin
            m_sticky <= 1'b1;
        end else if (mem_write) begin
            m_count <= m_count + 16'd1;
            if (funct3 == 3'b010) begin
                for (int k = 0; k < 4; k++) mm[addr[9:0] + 10'(k)] <= write_data[8*k +: 8];
            end else if (funct3 == 3'b001) begin
                for (int k = 0; k < 2; k++) mm[addr[9:0] + 10'(k)] <= write_data[8*k +: 8];
            end else begin
                mm[addr[9:0]] <= write_data[7:0];
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            if (reset) begin
                check("cyc_rd_rst", read_data, 32'h0);
                check("cyc_flt_rst", {31'h0, access_fault}, 32'h0);
            end else begin
                check("cyc_rd", read_data, m_read(mem_read, mem_write, funct3, addr));
                check("cyc_flt", {31'h0, access_fault},
                      {31'h0, m_fault(mem_read, mem_write, funct3, addr)});
            end
            check("cyc_sticky", {31'h0, fault_sticky}, {31'h0, m_sticky});
            check("cyc_count", {16'h0, store_count}, {16'h0, m_count});
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; write_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply a load and check its combinational result within the same cycle.
    task automatic load_chk(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp_rd, input logic exp_flt);
        drive(1'b1, 1'b0, f3, a, 32'h0);
        #2;
        check(name, read_data, exp_rd);
        check({name, "_flt"}, {31'h0, access_fault}, {31'h0, exp_flt});
        step();
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_count", {16'h0, store_count}, 32'h0);
        check("rst_sticky", {31'h0, fault_sticky}, 32'h0);
        check("rst_rd", read_data, 32'h0);
        step();

        // Word store and load.
        drive(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF); step();
        load_chk("lw_10", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        check("cnt_1", {16'h0, store_count}, 32'd1);

        // Byte store into lane 1.
        drive(1'b0, 1'b1, 3'b000, 32'h11, 32'h000000A5); step();
        load_chk("lw_10b", 3'b010, 32'h10, 32'hDEADA5EF, 1'b0);
        load_chk("lb_11", 3'b000, 32'h11, 32'hFFFFFFA5, 1'b0);
        load_chk("lbu_11", 3'b100, 32'h11, 32'h000000A5, 1'b0);

        // Halfword store into the upper half.
        drive(1'b0, 1'b1, 3'b001, 32'h22, 32'h00008001); step();
        load_chk("lh_22", 3'b001, 32'h22, 32'hFFFF8001, 1'b0);
        load_chk("lhu_22", 3'b101, 32'h22, 32'h00008001, 1'b0);
        load_chk("lw_20", 3'b010, 32'h20, 32'h80010000, 1'b0);

        // Misaligned word store faults and leaves memory alone.
        drive(1'b0, 1'b1, 3'b010, 32'h13, 32'h12345678);
        #2 check("sw13_flt", {31'h0, access_fault}, 32'd1);
        step();
        check("sw13_sticky", {31'h0, fault_sticky}, 32'd1);
        check("sw13_cnt", {16'h0, store_count}, 32'd3);
        load_chk("lw_10c", 3'b010, 32'h10, 32'hDEADA5EF, 1'b0);

        // Range boundary.
        load_chk("lw_400", 3'b010, 32'h400, 32'h0, 1'b1);
        load_chk("lw_3fc", 3'b010, 32'h3FC, 32'h0, 1'b0);

        // Byte lanes one at a time, then mixed-width reads.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 3'b000, 32'h40 + 32'(i), 32'(8'h11 * (i + 1)));
            step();
        end
        load_chk("lw_40", 3'b010, 32'h40, 32'h44332211, 1'b0);
        load_chk("lhu_42", 3'b101, 32'h42, 32'h00004433, 1'b0);
        load_chk("lb_43", 3'b000, 32'h43, 32'h00000044, 1'b0);

        // Illegal and misaligned forms.
        load_chk("lh_21", 3'b001, 32'h21, 32'h0, 1'b1);
        load_chk("f3_011", 3'b011, 32'h40, 32'h0, 1'b1);
        load_chk("f3_110", 3'b110, 32'h40, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 3'b100, 32'h40, 32'hFF);
        #2 check("sbu_flt", {31'h0, access_fault}, 32'd1);
        step();
        load_chk("lw_40b", 3'b010, 32'h40, 32'h44332211, 1'b0);
        check("cnt_7", {16'h0, store_count}, 32'd7);

        // Idle cycle: neither enable is high.
        drive(1'b0, 1'b0, 3'b011, 32'hFFFF_FFFF, 32'h0);
        #2 check("idle_flt", {31'h0, access_fault}, 32'h0);
        check("idle_rd", read_data, 32'h0);
        step();

        // Read-before-write with both enables high.
        drive(1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D);
        #2 check("rw_old", read_data, 32'h0);
        step();
        load_chk("rw_new", 3'b010, 32'h30, 32'hCAFEF00D, 1'b0);

        // Reset asserted between edges while a store is pending.
        drive(1'b0, 1'b1, 3'b010, 32'h30, 32'h11112222);
        #2 reset = 1'b1;
        #1;
        check("ar_cnt", {16'h0, store_count}, 32'h0);
        check("ar_sticky", {31'h0, fault_sticky}, 32'h0);
        reset = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        #1 check("ar_lw30", read_data, 32'h0);
        step();

        // Store counter wrap.
        for (int i = 0; i < 65535; i++) begin
            drive(1'b0, 1'b1, 3'b000, 32'(i % 1024), 32'(i));
            step();
        end
        check("cnt_ffff", {16'h0, store_count}, 32'h0000FFFF);
        drive(1'b0, 1'b1, 3'b010, 32'h0, 32'h5);
        step();
        check("cnt_wrap", {16'h0, store_count}, 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
